// File: rtl/grid_io_cfg_pkg.sv
// grid_io_cfg_pkg
// Shared definitions for the I/O grid tile configuration logic.
//   CFG_BITS   : mode bits per pad subtile
//   io_mode_e  : per-pad operating mode
//   chain_len  : length of the configuration shift chain for a given pad count,
//                including the trailing parity bit when GRID_IO_CFG_PARITY_EN is defined
// Optional feature macro: GRID_IO_CFG_PARITY_EN
package grid_io_cfg_pkg;

   localparam int CFG_BITS = 2;

   typedef enum logic [1:0] {
      IO_OFF  = 2'b00,
      IO_IN   = 2'b01,
      IO_OUT  = 2'b10,
      IO_LOOP = 2'b11
   } io_mode_e;

`ifdef GRID_IO_CFG_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // The parity bit, when present, is shifted last and sits below the mode bits.
   function automatic int chain_len(input int num_io);
      return num_io * CFG_BITS + PARITY_BITS;
   endfunction

endpackage

// File: rtl/grid_io_pad_ctrl.sv
// grid_io_pad_ctrl
// Combinational mode decode and isolation for one pad subtile.
// Ports:
//   mode     in   committed mode of this pad
//   isol_n   in   0 forces every output of this pad low
//   soc_in   in   pad input from the SoC
//   outpad   in   fabric data toward the pad
//   soc_out  out  pad output to the SoC
//   soc_dir  out  1 = pad driven by the FPGA
//   inpad    out  pad data toward the fabric
module grid_io_pad_ctrl
   import grid_io_cfg_pkg::*;
(
   input  io_mode_e mode,
   input  logic     isol_n,
   input  logic     soc_in,
   input  logic     outpad,
   output logic     soc_out,
   output logic     soc_dir,
   output logic     inpad
);

   // Isolation wins over every mode; OFF is the all-low default.
   always_comb begin
      soc_out = 1'b0;
      soc_dir = 1'b0;
      inpad   = 1'b0;
      if (isol_n) begin
         case (mode)
            IO_IN: begin
               inpad = soc_in;
            end
            IO_OUT: begin
               soc_out = outpad;
               soc_dir = 1'b1;
            end
            IO_LOOP: begin
               soc_out = outpad;
               soc_dir = 1'b1;
               inpad   = soc_in;
            end
            default: begin
               soc_out = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/grid_io_bank_cfg.sv
// grid_io_bank_cfg
// I/O grid tile with NUM_IO pad subtiles, one configuration shift chain and a
// double-buffered (staging -> shadow) configuration with a bit-count guarded commit.
// Ports:
//   prog_clk, prog_reset         clock and synchronous active-high reset
//   isol_n                       0 = isolate all pads
//   ccff_head/ccff_shift         serial config data and shift enable
//   ccff_commit                  load staging into shadow (if the count is right)
//   ccff_tail                    staging MSB (registered)
//   gfpga_pad_io_soc_in/out/dir  SoC pad ring side
//   fabric_outpad/fabric_inpad   routing fabric side
//   cfg_valid                    shadow holds a committed configuration
//   cfg_error                    sticky: a commit was rejected
// Optional feature macro: GRID_IO_CFG_PARITY_EN (adds an even-parity bit to the chain)
module grid_io_bank_cfg
   import grid_io_cfg_pkg::*;
#(
   parameter int NUM_IO   = 4,
   parameter int CFG_BITS = 2
)(
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              isol_n,
   input  logic              ccff_head,
   input  logic              ccff_shift,
   input  logic              ccff_commit,
   output logic              ccff_tail,
   input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
   output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
   output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
   input  logic [NUM_IO-1:0] fabric_outpad,
   output logic [NUM_IO-1:0] fabric_inpad,
   output logic              cfg_valid,
   output logic              cfg_error
);

   localparam int TOTAL = NUM_IO * CFG_BITS;
   localparam int CHAIN = chain_len(NUM_IO);
   localparam int CW    = $clog2(CHAIN + 1);

   if (CFG_BITS != grid_io_cfg_pkg::CFG_BITS) begin : g_bad_cfg_bits
      $error("grid_io_bank_cfg: CFG_BITS must match the package constant");
   end
   if (NUM_IO < 1 || NUM_IO > 64) begin : g_bad_num_io
      $error("grid_io_bank_cfg: NUM_IO out of range 1..64");
   end

   logic [CHAIN-1:0] stage;
   logic [TOTAL-1:0] shadow;
   logic [CW-1:0]    bit_cnt;
   logic             overflow;
   logic             parity_ok;
   logic             commit_ok;

`ifdef GRID_IO_CFG_PARITY_EN
   assign parity_ok = ~^stage;
`else
   assign parity_ok = 1'b1;
`endif

   // Commit judges the pre-shift chain and count, so a same-cycle shift is harmless.
   assign commit_ok = (bit_cnt == CW'(CHAIN)) && !overflow && parity_ok;

   // The stage MSB is already a flop, so the tail has no path from the head.
   assign ccff_tail = stage[CHAIN-1];

   // Chain, counter, shadow and status; a commit always restarts the count,
   // at 1 if a shift lands in the same cycle.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         stage     <= '0;
         shadow    <= '0;
         bit_cnt   <= '0;
         overflow  <= 1'b0;
         cfg_valid <= 1'b0;
         cfg_error <= 1'b0;
      end else begin
         if (ccff_shift) begin
            stage <= {stage[CHAIN-2:0], ccff_head};
         end
         if (ccff_commit) begin
            if (commit_ok) begin
               shadow    <= stage[CHAIN-1 -: TOTAL];
               cfg_valid <= 1'b1;
            end else begin
               cfg_error <= 1'b1;
            end
            overflow <= 1'b0;
            bit_cnt  <= ccff_shift ? CW'(1) : '0;
         end else if (ccff_shift) begin
            if (bit_cnt == CW'(CHAIN)) begin
               overflow <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
      grid_io_pad_ctrl u_pad (
         .mode    (io_mode_e'(shadow[i*CFG_BITS +: CFG_BITS])),
         .isol_n  (isol_n),
         .soc_in  (gfpga_pad_io_soc_in[i]),
         .outpad  (fabric_outpad[i]),
         .soc_out (gfpga_pad_io_soc_out[i]),
         .soc_dir (gfpga_pad_io_soc_dir[i]),
         .inpad   (fabric_inpad[i])
      );
   end

endmodule
